// File: rtl/arbiter_round_robin_hold_pkg.sv
// Shared helpers for the round-robin hold arbiter: width math and
// one-hot to binary encoding.
package arbiter_round_robin_hold_pkg;

    localparam int unsigned MAX_VECTOR_WIDTH = 32;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Only the low 'width' bits of the vector take part in the encoding.
    function automatic logic [31:0] onehot_encode(
        input logic [MAX_VECTOR_WIDTH-1:0] onehot,
        input int unsigned                 width
    );
        logic [31:0] index;
        index = 32'd0;
        for (int unsigned i = 0; i < MAX_VECTOR_WIDTH; i++) begin
            if ((i < width) && onehot[i]) begin
                index = index | i;
            end else begin
                index = index;
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/arbiter_round_robin_hold_priority_lsb_select.sv
// Combinational rotating priority pick: lowest set bit strictly above a
// one-hot pointer, else the lowest set bit overall, else zero.
module priority_lsb_select #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] vector,
    input  logic [WIDTH-1:0] pointer,
    output logic [WIDTH-1:0] select
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(32'd0);

    logic [WIDTH-1:0] higher_s;
    logic [WIDTH-1:0] masked_s;

    // A pointer at the MSB yields an empty mask, forcing the wrap-around pick.
    always_comb begin
        higher_s = ~(pointer ^ (pointer - ONE));
        masked_s = vector & higher_s;
        if (masked_s != ZERO) begin
            select = masked_s & (~masked_s + ONE);
        end else if (vector != ZERO) begin
            select = vector & (~vector + ONE);
        end else begin
            select = ZERO;
        end
    end

endmodule

// File: rtl/arbiter_round_robin_hold.sv
// Registered round-robin arbiter with grant hold: the winner keeps the
// resource until it drops its request, then the grant rotates upward.
module arbiter_round_robin_hold
    import arbiter_round_robin_hold_pkg::*;
#(
    parameter int unsigned INPUT_COUNT = 8,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INPUT_COUNT-1:0] requests,
    output logic [INPUT_COUNT-1:0] grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   grant_valid,
    output logic                   grant_changed
);

    localparam logic [INPUT_COUNT-1:0] ZERO     = INPUT_COUNT'(32'd0);
    localparam logic [INPUT_COUNT-1:0] MSB_ONLY = {1'b1, {(INPUT_COUNT-1){1'b0}}};

    if ((INPUT_COUNT < 32'd2) || (INDEX_WIDTH != clog2(INPUT_COUNT))) begin : g_param_check
        $error("arbiter_round_robin_hold: INPUT_COUNT must be >= 2 and INDEX_WIDTH = clog2(INPUT_COUNT)");
    end

    logic [INPUT_COUNT-1:0] grant_r;
    logic [INPUT_COUNT-1:0] last_grant_r;
    logic [INDEX_WIDTH-1:0] index_r;
    logic                   valid_r;
    logic                   changed_r;

    logic [INPUT_COUNT-1:0] rotate_s;
    logic [INPUT_COUNT-1:0] next_s;
    logic [INDEX_WIDTH-1:0] encoded_s;

    priority_lsb_select #(
        .WIDTH (INPUT_COUNT)
    ) u_select (
        .vector  (requests),
        .pointer (last_grant_r),
        .select  (rotate_s)
    );

    // Hold the current winner while it still requests, otherwise rotate.
    always_comb begin
        next_s = ZERO;
        if ((grant_r & requests) != ZERO) begin
            next_s = grant_r;
        end else begin
            next_s = rotate_s;
        end
        encoded_s = INDEX_WIDTH'(onehot_encode(MAX_VECTOR_WIDTH'(next_s), INPUT_COUNT));
    end

    // State and output registers; last_grant and index survive idle gaps.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_r      <= ZERO;
            last_grant_r <= MSB_ONLY;
            index_r      <= INDEX_WIDTH'(32'd0);
            valid_r      <= 1'b0;
            changed_r    <= 1'b0;
        end else begin
            grant_r   <= next_s;
            valid_r   <= (next_s != ZERO);
            changed_r <= (next_s != grant_r);
            if (next_s != ZERO) begin
                last_grant_r <= next_s;
                index_r      <= encoded_s;
            end else begin
                last_grant_r <= last_grant_r;
                index_r      <= index_r;
            end
        end
    end

    assign grant         = grant_r;
    assign grant_index   = index_r;
    assign grant_valid   = valid_r;
    assign grant_changed = changed_r;

endmodule

// File: tb/tb_arbiter_round_robin_hold.sv
// Directed self-checking bench for arbiter_round_robin_hold (8 requesters).
module tb_arbiter_round_robin_hold;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] requests = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_index;
    logic       grant_valid;
    logic       grant_changed;
    logic       started = 1'b0;

    int total = 0;
    int bad   = 0;

    arbiter_round_robin_hold #(
        .INPUT_COUNT (8),
        .INDEX_WIDTH (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .requests      (requests),
        .grant         (grant),
        .grant_index   (grant_index),
        .grant_valid   (grant_valid),
        .grant_changed (grant_changed)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expect_state(input string tag, input logic [7:0] g,
                                input logic [2:0] idx, input logic v, input logic c);
        check_value({tag, ".grant"},   32'(grant),         32'(g));
        check_value({tag, ".index"},   32'(grant_index),   32'(idx));
        check_value({tag, ".valid"},   32'(grant_valid),   32'(v));
        check_value({tag, ".changed"}, 32'(grant_changed), 32'(c));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Grant must be one-hot or zero on every cycle once reset has been applied.
    always @(negedge clock) begin
        if (started) begin
            check_value("onehot0", 32'($onehot0(grant)), 32'd1);
        end
    end

    initial begin
        step();
        step();
        started = 1'b1;
        expect_state("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        reset = 1'b0;
        requests = 8'b0000_0101;
        step();
        expect_state("first", 8'b0000_0001, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_state("hold", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
        end
        requests = 8'b0000_0100;
        step();
        expect_state("release", 8'b0000_0100, 3'd2, 1'b1, 1'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        requests = 8'hFF;
        step();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] own;
            logic [7:0] nxt;
            own = 8'(32'd1 << k);
            nxt = 8'(32'd1 << ((k + 1) % 8));
            check_value("rot.first", 32'(grant), 32'(own));
            check_value("rot.index", 32'(grant_index), 32'(k));
            step();
            expect_state("rot.held", own, 3'(k), 1'b1, 1'b0);
            requests = 8'hFF & ~own;
            step();
            expect_state("rot.next", nxt, 3'((k + 1) % 8), 1'b1, 1'b1);
            requests = 8'hFF;
        end

        requests = 8'b1000_0000;
        step();
        expect_state("to7", 8'b1000_0000, 3'd7, 1'b1, 1'b1);
        requests = 8'h00;
        step();
        expect_state("idle7", 8'h00, 3'd7, 1'b0, 1'b1);
        requests = 8'b1000_0010;
        step();
        expect_state("wrap", 8'b0000_0010, 3'd1, 1'b1, 1'b1);
        requests = 8'b1000_0000;
        step();
        expect_state("wrap.up", 8'b1000_0000, 3'd7, 1'b1, 1'b1);

        requests = 8'b0000_1000;
        step();
        expect_state("to3", 8'b0000_1000, 3'd3, 1'b1, 1'b1);
        requests = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_state("idle3", 8'h00, 3'd3, 1'b0, (i == 0) ? 1'b1 : 1'b0);
        end
        requests = 8'b0000_1001;
        step();
        expect_state("after_idle", 8'b0000_0001, 3'd0, 1'b1, 1'b1);

        requests = 8'h00;
        step();
        expect_state("single.off", 8'h00, 3'd0, 1'b0, 1'b1);
        requests = 8'b0000_0001;
        step();
        expect_state("single.again", 8'b0000_0001, 3'd0, 1'b1, 1'b1);

        requests = 8'b0001_0000;
        step();
        expect_state("to4", 8'b0001_0000, 3'd4, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        expect_state("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        requests = 8'b1001_0000;
        step();
        expect_state("post_reset", 8'b0001_0000, 3'd4, 1'b1, 1'b1);

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter_round_robin_hold.md
Name: arbiter_round_robin_hold

Overview:
- Registered round-robin arbiter that shares one resource among INPUT_COUNT requesters.
- A grant is held for as long as the granted requester keeps its request asserted; there is no preemption.
- On release, the grant passes to the next requester strictly more significant than the last winner, wrapping around to bit 0.
- Sits in front of shared ports (memory, I/O, accelerators) and supplies the one-hot select plus its binary index.

Parameters:
- INPUT_COUNT, 8, number of requesters; must be >= 2.
- INDEX_WIDTH, 3, width of grant_index; must equal clog2(INPUT_COUNT).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- requests  input  INPUT_COUNT  level request per requester; bit i is requester i.
- grant  output  INPUT_COUNT  registered one-hot grant, or all-zero when idle.
- grant_index  output  INDEX_WIDTH  registered binary index of the set grant bit; holds its last value when idle.
- grant_valid  output  1  registered; high when grant is non-zero.
- grant_changed  output  1  registered one-cycle pulse when grant differs from its previous-cycle value.

Behaviour:
- State:
  - grant register (one-hot or zero).
  - last_grant register: always one-hot; the most recent non-zero grant.
- Reset values:
  - grant = 0, grant_valid = 0, grant_index = 0, grant_changed = 0.
  - last_grant = one-hot MSB (bit INPUT_COUNT-1), so bit 0 has highest priority after reset.
  - Reset overrides all other inputs. Reset during an active grant drops it on the next edge.
- Next-grant computation (combinational, registered every cycle):
  1. HOLD: if (grant & requests) != 0, next = grant.
  2. Otherwise, build a mask of the bits strictly more significant than last_grant: higher = ~(last_grant ^ (last_grant - 1)).
  3. Form masked = requests & higher.
  4. If masked != 0, next = lowest set bit of masked, computed as x & (~x + 1).
  5. Else if requests != 0, next = lowest set bit of requests (wrap-around).
  6. Else next = 0 (idle).
- Register updates:
  - last_grant <= next when next != 0; otherwise last_grant is unchanged, so fairness survives idle gaps.
  - grant_index <= encode(next) when next != 0; otherwise unchanged.
  - grant_valid <= (next != 0).
  - grant_changed <= (next != grant).
- Latency:
  - A request asserted in cycle N to an idle arbiter is granted in cycle N+1.
  - A release in cycle N hands over in cycle N+1, with no dead cycle.
- Simultaneous events: a release and a new request in the same cycle pick the winner by rotation. Requests that appear while a grant is held wait.
- Boundaries:
  - last_grant at MSB: higher = 0, so the choice always wraps to the lowest set request.
  - A single requester re-requesting after release is re-granted.
  - All requests asserted: a requester that releases its grant hands over in index order 0,1,...,N-1,0.
- Invariant: grant is one-hot or zero. The bench asserts $onehot0(grant) every cycle.
- Arithmetic: all vectors are INPUT_COUNT wide, and subtraction wraps modulo 2^INPUT_COUNT. last_grant is never zero, so there is no all-zero mask case.

Decomposition:
- Shared package: clog2 function, and a one-hot-to-binary encode function parameterized by width.
- One sub-module, priority_lsb_select: combinational, takes a vector and a one-hot pointer, and returns the lowest set bit strictly above the pointer, else the lowest set bit overall, else zero.
- The arbiter core holds only the registers and the hold/update logic.

Test Plan:
- Reset release with requests=0000_0101 (INPUT_COUNT=8) -> cycle+1: grant=0000_0001, grant_index=0, grant_valid=1, grant_changed=1.
- Hold: keep requests=0000_0101 for 5 cycles -> grant stays 0000_0001 and grant_changed=0 after the first cycle. Then drop bit 0 -> next cycle grant=0000_0100, index=2, grant_changed=1.
- Rotation: requests=1111_1111, and each granted requester releases for 1 cycle after 2 cycles of grant -> grant index sequence 0,1,2,...,7,0. No requester is skipped or granted twice in a row.
- Wrap: last winner index 7, then requests=1000_0010 -> grant=0000_0010. After bit 1 releases -> grant=1000_0000.
- Idle memory: grant index 3, then requests=0 for 4 cycles (grant_valid=0, grant_index=3), then requests=0000_1001 -> grant=0000_0001 (rotation from 3 wraps, since nothing above 3 is set).
- Reset mid-grant: reset asserted while grant=0001_0000 -> next cycle grant=0, valid=0. After reset, requests=1001_0000 -> grant=0001_0000 (priority restarts from bit 0).
